// File: rtl/idea_round_engine_pkg.sv
// Shared constants, FSM encoding and subkey addressing for the IDEA round engine.
package idea_pkg;

    localparam int BLOCK_W        = 64;
    localparam int SUBKEY_W       = 16;
    localparam int NUM_SUBKEYS    = 52;
    localparam int NUM_ROUNDS     = 8;
    localparam int KEYLIST_W      = 896;
    localparam int KEYS_PER_ROUND = 6;
    localparam int KEYREG_W       = NUM_SUBKEYS * SUBKEY_W;
    localparam int OUT_KEY_BASE   = NUM_SUBKEYS - 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        OUTT  = 2'd2
    } state_t;

    function automatic int subkey_off(input int k);
        return k * SUBKEY_W;
    endfunction

endpackage

// File: rtl/idea_round_engine_if.sv
// Request/result bundle between a block source (master) and the IDEA round engine (slave).
interface idea_round_engine_if;
    import idea_pkg::*;

    logic                 start;
    logic [0:BLOCK_W-1]   dataIn;
    logic [0:KEYLIST_W-1] keysList;
    logic [0:BLOCK_W-1]   dataOut;
    logic                 busy;
    logic                 done;

    modport master (
        output start, dataIn, keysList,
        input  dataOut, busy, done
    );

    modport slave (
        input  start, dataIn, keysList,
        output dataOut, busy, done
    );

endinterface

// File: rtl/idea_round_engine_mulmod.sv
// IDEA multiply modulo 2^W+1; an all-zero operand or result stands for 2^W.
module idea_mulmod #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] p
);

    logic [2*W-1:0] prod;
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic [W-1:0]   diff;

    assign prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    assign lo   = prod[W-1:0];
    assign hi   = prod[2*W-1:W];
    // 2^W is -1 modulo 2^W+1, so hi*2^W + lo folds to lo - hi, plus one when it wraps.
    assign diff = lo - hi + W'(lo < hi);

    // A zero operand is -1, so the product is simply the negated other operand.
    always_comb begin
        if (x == '0)
            p = W'(1) - y;
        else if (y == '0)
            p = W'(1) - x;
        else
            p = diff;
    end

endmodule

// File: rtl/idea_round_engine.sv
// Iterative IDEA datapath: one full round per clock for NUM_ROUNDS clocks, then the output transform.
module idea_round_engine
    import idea_pkg::state_t, idea_pkg::IDLE, idea_pkg::ROUND, idea_pkg::OUTT,
           idea_pkg::NUM_SUBKEYS, idea_pkg::KEYREG_W, idea_pkg::KEYLIST_W,
           idea_pkg::KEYS_PER_ROUND, idea_pkg::OUT_KEY_BASE, idea_pkg::subkey_off;
#(
    parameter int NUM_ROUNDS = idea_pkg::NUM_ROUNDS,
    parameter int SUBKEY_W   = idea_pkg::SUBKEY_W
) (
    input logic                clk,
    input logic                rst,
    idea_round_engine_if.slave bus
);

    localparam int RW     = $clog2(NUM_ROUNDS + 1);
    localparam int KOFF_W = $clog2(KEYREG_W);
    localparam int KIDX_W = $clog2(NUM_SUBKEYS + KEYS_PER_ROUND);

    typedef logic [SUBKEY_W-1:0] word_t;

    state_t              state_q;
    state_t              state_d;
    logic                accept;
    logic [RW-1:0]       round_q;
    logic [0:KEYREG_W-1] key_q;
    word_t               w1_q, w2_q, w3_q, w4_q;
    logic [0:4*SUBKEY_W-1] data_out_q;
    logic                done_q;

    logic [KIDX_W-1:0]   key_base;
    word_t               rk [KEYS_PER_ROUND];
    word_t               a, b, c, d, e, f, g, h, i, j;
    logic                unused_pad;

    // Padding subkey slots beyond K51 are deliberately dropped.
    assign unused_pad = ^bus.keysList[KEYREG_W:KEYLIST_W-1];

    // NOTE: defaults are assigned before the case so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (round_q == RW'(NUM_ROUNDS - 1))
                    state_d = OUTT;
            end
            OUTT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // The output transform reuses the round key window, rebased onto K48..K51.
    assign key_base = (state_q == OUTT) ? KIDX_W'(OUT_KEY_BASE)
                                        : KIDX_W'(KEYS_PER_ROUND * int'(round_q));

    always_comb begin
        for (int n = 0; n < KEYS_PER_ROUND; n++) begin
            rk[n] = '0;
            if (int'(key_base) + n < NUM_SUBKEYS)
                rk[n] = key_q[KOFF_W'(subkey_off(int'(key_base) + n)) +: SUBKEY_W];
        end
    end

    // In OUTT the adder inputs swap so that the final round's W2/W3 exchange is undone.
    assign b = ((state_q == OUTT) ? w3_q : w2_q) + rk[1];
    assign c = ((state_q == OUTT) ? w2_q : w3_q) + rk[2];

    idea_mulmod #(.W(SUBKEY_W)) u_mul_a (.x(w1_q), .y(rk[0]), .p(a));
    idea_mulmod #(.W(SUBKEY_W)) u_mul_d (.x(w4_q), .y(rk[3]), .p(d));

    assign e = a ^ c;
    assign f = b ^ d;

    idea_mulmod #(.W(SUBKEY_W)) u_mul_g (.x(e), .y(rk[4]), .p(g));

    assign h = f + g;

    idea_mulmod #(.W(SUBKEY_W)) u_mul_i (.x(h), .y(rk[5]), .p(i));

    assign j = g + i;

    // NOTE: the wide key register is reset too, so an aborted operation leaves no stale subkeys behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_q    <= '0;
            key_q      <= '0;
            w1_q       <= '0;
            w2_q       <= '0;
            w3_q       <= '0;
            w4_q       <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                {w1_q, w2_q, w3_q, w4_q} <= bus.dataIn;
                key_q   <= bus.keysList[0:KEYREG_W-1];
                round_q <= '0;
            end else if (state_q == ROUND) begin
                w1_q    <= a ^ i;
                w2_q    <= c ^ i;
                w3_q    <= b ^ j;
                w4_q    <= d ^ j;
                round_q <= round_q + 1'b1;
            end else if (state_q == OUTT) begin
                data_out_q <= {a, b, c, d};
                done_q     <= 1'b1;
            end
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.dataOut = data_out_q;

endmodule

// File: tb/tb_idea_round_engine.sv
// Scoreboard bench for idea_round_engine: random and directed blocks checked against an arithmetic IDEA model.
module tb_idea_round_engine;
    import idea_pkg::*;

    localparam logic [127:0] STD_KEY = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [0:63]  STD_PT  = 64'h0000_0001_0002_0003;
    localparam logic [0:63]  STD_CT  = 64'h11FB_ED2B_0198_6DE5;

    localparam logic [15:0] MUL_TV [5][3] = '{
        '{16'h0000, 16'h0000, 16'h0001},
        '{16'h0000, 16'h0001, 16'h0000},
        '{16'hFFFF, 16'hFFFF, 16'h0004},
        '{16'h8000, 16'h0002, 16'h0000},
        '{16'h0003, 16'h0005, 16'h000F}
    };

    typedef struct {
        logic [0:63] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    exp_t        exp_q[$];
    logic [15:0] mx, my, mp;

    idea_round_engine_if ifc();

    idea_round_engine #(.NUM_ROUNDS(NUM_ROUNDS), .SUBKEY_W(SUBKEY_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    idea_mulmod #(.W(16)) u_mul (.x(mx), .y(my), .p(mp));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mul(input logic [15:0] a, input logic [15:0] b);
        longint unsigned xa, xb, r;
        xa = (a == 16'h0) ? 65536 : longint'(a);
        xb = (b == 16'h0) ? 65536 : longint'(b);
        r  = (xa * xb) % 65537;
        return (r == 65536) ? 16'h0000 : r[15:0];
    endfunction

    // 52 subkeys: eight 16-bit slices of the key, then rotate the key left by 25, repeat.
    function automatic logic [0:895] sched(input logic [127:0] key);
        logic [0:895] kl;
        logic [127:0] k;
        kl = '0;
        k  = key;
        for (int n = 0; n < NUM_SUBKEYS; n++) begin
            kl[n*16 +: 16] = k[127 - 16*(n % 8) -: 16];
            if (n % 8 == 7)
                k = {k[102:0], k[127:103]};
        end
        return kl;
    endfunction

    function automatic logic [0:63] idea_ref(input logic [0:63] blk, input logic [0:895] kl);
        logic [15:0] k [NUM_SUBKEYS];
        logic [15:0] x [4];
        logic [15:0] t1, t2, t3, t4, t5, t6, t7;
        for (int n = 0; n < NUM_SUBKEYS; n++) k[n] = kl[n*16 +: 16];
        for (int n = 0; n < 4; n++) x[n] = blk[n*16 +: 16];
        for (int r = 0; r < NUM_ROUNDS; r++) begin
            t1 = mul(x[0], k[6*r]);
            t2 = x[1] + k[6*r+1];
            t3 = x[2] + k[6*r+2];
            t4 = mul(x[3], k[6*r+3]);
            t5 = mul(t1 ^ t3, k[6*r+4]);
            t6 = mul((t2 ^ t4) + t5, k[6*r+5]);
            t7 = t5 + t6;
            x[0] = t1 ^ t6;
            x[1] = t3 ^ t6;
            x[2] = t2 ^ t7;
            x[3] = t4 ^ t7;
        end
        return {mul(x[0], k[48]), 16'(x[2] + k[49]), 16'(x[1] + k[50]), mul(x[3], k[51])};
    endfunction

    function automatic logic [0:895] rand_kl();
        logic [0:895] kl;
        for (int n = 0; n < 28; n++) kl[n*32 +: 32] = $urandom;
        return kl;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic issue(input logic [0:63] d, input logic [0:895] k, input logic [0:63] e, output int t);
        @(negedge clk);
        ifc.start    = 1'b1;
        ifc.dataIn   = d;
        ifc.keysList = k;
        t = cyc + 1;
        exp_q.push_back('{data: e, cyc: t + 9});
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && ifc.done) begin
            done_cnt++;
            check("busy_low_at_done", 64'(ifc.busy), 64'd0);
            check("pending_result", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dataOut", ifc.dataOut, e.data);
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           t, t0, dc;
        logic [0:895] std_kl, kl;
        logic [0:63]  d;
        logic [127:0] key;

        rst          = 1'b1;
        ifc.start    = 1'b0;
        ifc.dataIn   = '0;
        ifc.keysList = '0;
        mx           = '0;
        my           = '0;
        std_kl       = sched(STD_KEY);

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(ifc.busy), 64'd0);
        check("reset_done", 64'(ifc.done), 64'd0);
        check("reset_dataOut", ifc.dataOut, 64'd0);
        rst = 1'b0;

        for (int n = 0; n < 5; n++) begin
            mx = MUL_TV[n][0];
            my = MUL_TV[n][1];
            #1;
            check("mulmod_edge", 64'(mp), 64'(MUL_TV[n][2]));
        end
        for (int n = 0; n < 16; n++) begin
            mx = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            my = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            #1;
            check("mulmod_rand", 64'(mp), 64'(mul(mx, my)));
        end

        check("model_std_vector", idea_ref(STD_PT, std_kl), STD_CT);

        // Standard vector with busy-length measurement.
        issue(STD_PT, std_kl, STD_CT, t);
        dc = 0;
        for (int n = 0; n < 12; n++) begin
            if (ifc.busy) dc++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(dc), 64'd9);
        drain();

        // A start while busy is dropped and yields no extra done.
        t0 = done_cnt;
        issue(STD_PT, std_kl, STD_CT, t);
        wait_cyc(t + 2);
        ifc.start  = 1'b1;
        ifc.dataIn = '1;
        @(negedge clk);
        ifc.start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        check("single_done", 64'(done_cnt - t0), 64'd1);

        // Asynchronous reset in mid-operation.
        issue(STD_PT, std_kl, STD_CT, t);
        wait_cyc(t + 3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 64'(ifc.busy), 64'd0);
        check("abort_done", 64'(ifc.done), 64'd0);
        check("abort_dataOut", ifc.dataOut, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(STD_PT, std_kl, STD_CT, t);
        drain();

        // Input isolation, back-to-back start in the done cycle, padding bits set.
        kl = std_kl;
        kl[832:895] = '1;
        issue(STD_PT, std_kl, STD_CT, t);
        ifc.dataIn   = {$urandom, $urandom};
        ifc.keysList = rand_kl();
        wait_cyc(t + 8);
        issue(STD_PT, kl, STD_CT, t0);
        ifc.dataIn   = {$urandom, $urandom};
        ifc.keysList = rand_kl();
        drain();

        // Random keys and blocks with random idle gaps, including zero gaps.
        for (int n = 0; n < 24; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            kl  = sched(key);
            d   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) d[0:15] = '0;
            if ($urandom_range(0, 3) == 0) d[48:63] = '0;
            issue(d, kl, idea_ref(d, kl), t);
            if ($urandom_range(0, 1) == 1) begin
                ifc.dataIn   = {$urandom, $urandom};
                ifc.keysList = rand_kl();
            end
            wait_cyc(t + 8 + int'($urandom_range(0, 3)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
